// File: rtl/ram_port_arbiter_if.sv
// Host-side and RAM-side bundle for ram_port_arbiter.
// slave = arbiter view, master = hosts/RAM view.
interface ram_port_arbiter_if #(
  parameter int NumHosts = 2
);
  logic [NumHosts-1:0]    host_req_i;
  logic [NumHosts-1:0]    host_gnt_o;
  logic [NumHosts-1:0]    host_we_i;
  logic [NumHosts*4-1:0]  host_be_i;
  logic [NumHosts*32-1:0] host_addr_i;
  logic [NumHosts*32-1:0] host_wdata_i;
  logic [NumHosts-1:0]    host_rvalid_o;
  logic [NumHosts*32-1:0] host_rdata_o;
  logic [NumHosts-1:0]    host_err_o;
  logic                   mem_req_o;
  logic                   mem_we_o;
  logic [3:0]             mem_be_o;
  logic [31:0]            mem_addr_o;
  logic [31:0]            mem_wdata_o;
  logic                   mem_rvalid_i;
  logic [31:0]            mem_rdata_i;

  modport slave (
    input  host_req_i, host_we_i, host_be_i,
    input  host_addr_i, host_wdata_i,
    input  mem_rvalid_i, mem_rdata_i,
    output host_gnt_o, host_rvalid_o,
    output host_rdata_o, host_err_o,
    output mem_req_o, mem_we_o, mem_be_o,
    output mem_addr_o, mem_wdata_o
  );

  modport master (
    output host_req_i, host_we_i, host_be_i,
    output host_addr_i, host_wdata_i,
    output mem_rvalid_i, mem_rdata_i,
    input  host_gnt_o, host_rvalid_o,
    input  host_rdata_o, host_err_o,
    input  mem_req_o, mem_we_o, mem_be_o,
    input  mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-cycle RAM port
// between NumHosts requesters, with local out-of-range errors.
module ram_port_arbiter #(
  parameter int NumHosts = 2,
  parameter int Depth    = 128
) (
  input logic               clk_i,
  input logic               rst_i,
  ram_port_arbiter_if.slave bus
);
  localparam int HostIdxW = $clog2(NumHosts);

  logic [HostIdxW-1:0] ptr;
  logic [HostIdxW-1:0] win;
  logic [HostIdxW-1:0] pend_idx;
  logic                found;
  logic                gnt_any;
  logic                oor;
  logic                pend_valid;
  logic                pend_err;
  logic [31:0]         win_addr;

  // first requester at or after ptr, wrapping
  always_comb begin
    int k;
    found = 1'b0;
    win   = '0;
    k     = 0;
    for (int i = 0; i < NumHosts; i++) begin
      k = int'(ptr) + i;
      if (k >= NumHosts) k = k - NumHosts;
      if (!found && bus.host_req_i[k]) begin
        found = 1'b1;
        win   = HostIdxW'(k);
      end
    end
  end

  assign gnt_any  = found & ~rst_i;
  assign win_addr = bus.host_addr_i[32*win +: 32];
  assign oor      = {2'b00, win_addr[31:2]} >= 32'(Depth);

  always_comb begin
    bus.host_gnt_o  = '0;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_be_o    = '0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    if (gnt_any) begin
      bus.host_gnt_o  = NumHosts'(1) << win;
      bus.mem_req_o   = ~oor;
      bus.mem_we_o    = bus.host_we_i[win];
      bus.mem_be_o    = bus.host_be_i[4*win +: 4];
      bus.mem_addr_o  = win_addr;
      bus.mem_wdata_o = bus.host_wdata_i[32*win +: 32];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr        <= '0;
      pend_valid <= 1'b0;
      pend_idx   <= '0;
      pend_err   <= 1'b0;
    end else begin
      pend_valid <= gnt_any;
      pend_idx   <= win;
      pend_err   <= oor;
      if (gnt_any) begin
        if (win == HostIdxW'(NumHosts - 1)) ptr <= '0;
        else ptr <= win + 1'b1;
      end
    end
  end

  // response steered from pending state; RAM data is same-cycle
  always_comb begin
    bus.host_rvalid_o = '0;
    bus.host_err_o    = '0;
    bus.host_rdata_o  = '0;
    if (pend_valid) begin
      bus.host_rvalid_o[pend_idx] = 1'b1;
      bus.host_err_o[pend_idx]    = pend_err;
      bus.host_rdata_o[32*pend_idx +: 32] =
        pend_err ? 32'h0 : bus.mem_rdata_i;
    end
  end

  a_gnt_onehot: assert property (
    @(posedge clk_i) disable iff (rst_i)
    $onehot0(bus.host_gnt_o));

  a_req_gnt: assert property (
    @(posedge clk_i) disable iff (rst_i)
    bus.mem_req_o |-> |bus.host_gnt_o);

  a_resp: assert property (
    @(posedge clk_i) disable iff (rst_i)
    |bus.host_gnt_o |=>
      bus.host_rvalid_o == $past(bus.host_gnt_o));

  a_ram_lat: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (pend_valid && !pend_err) |-> bus.mem_rvalid_i);
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one port of the 32-bit single-cycle on-chip RAM between NumHosts requesters (e.g. core data port, debug module, DMA).
- Round-robin arbitration, one grant per cycle; memory request forwarded in the same cycle.
- One-cycle read response routed back to the granted host.
- Out-of-range accesses answered locally with an error response; they never reach the RAM.

Parameters:
- NumHosts, 2, number of requesting hosts; legal range 2..8.
- Depth, 128, RAM depth in 32-bit words; word addresses >= Depth are out of range.
- HostIdxW, $clog2(NumHosts), derived (localparam); width of the granted-host index.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset; asynchronous, active-high.
- host_req_i  input  NumHosts  per-host request, level; held until granted.
- host_gnt_o  output  NumHosts  per-host grant, one-hot or zero; combinational from requests.
- host_we_i  input  NumHosts  per-host write enable.
- host_be_i  input  NumHosts*4  per-host byte enables; host h at [4h+:4].
- host_addr_i  input  NumHosts*32  per-host byte address; host h at [32h+:32].
- host_wdata_i  input  NumHosts*32  per-host write data.
- host_rvalid_o  output  NumHosts  per-host response valid; registered.
- host_rdata_o  output  NumHosts*32  per-host read data.
- host_err_o  output  NumHosts  per-host error flag; qualified by rvalid.
- mem_req_o  output  1  RAM request.
- mem_we_o  output  1  RAM write enable.
- mem_be_o  output  4  RAM byte enables.
- mem_addr_o  output  32  RAM byte address.
- mem_wdata_o  output  32  RAM write data.
- mem_rvalid_i  input  1  RAM response valid; one cycle after mem_req_o.
- mem_rdata_i  input  32  RAM read data.

Behaviour:
- Reset (rst_i high, async):
  - host_rvalid_o, host_err_o, host_rdata_o = 0.
  - Priority pointer = 0; pending-response registers cleared.
  - mem_req_o and host_gnt_o are combinational, but they are forced to 0 while rst_i is high.
- Arbitration:
  - Winner = first requesting host at or after the priority pointer, searching upward and wrapping.
  - Exactly one host_gnt_o bit is high when any request is present; all bits are 0 when none are.
  - On a grant, the pointer updates at the clock edge to (winner+1) mod NumHosts; with no grant it holds.
  - Wrap example: NumHosts=3, winner 2 -> pointer 0.
- Range check: out_of_range = granted host_addr[31:2] >= Depth; address bits [1:0] are passed through unchecked.
- Forwarding, granted and in range:
  - mem_req_o=1 in the same cycle.
  - mem_we/be/addr/wdata are muxed from the winner.
- Forwarding, granted and out of range:
  - mem_req_o=0; the grant is still given and the pointer still advances.
- When idle: mem_* data outputs = 0.
- Pending registers, updated every cycle:
  - pend_valid <= any grant.
  - pend_idx <= winner.
  - pend_err <= out_of_range.
- Response cycle (the cycle after a grant), when pend_valid=1:
  - host_rvalid_o[pend_idx]=1.
  - If pend_err: host_err_o[pend_idx]=1, host_rdata_o[pend_idx]=0, and mem_rvalid_i is ignored.
  - Else: host_rdata_o[pend_idx]=mem_rdata_i, host_err_o=0.
  - Writes also produce exactly one rvalid pulse; rdata is don't-care for writes but is driven from mem_rdata_i.
- Outputs are registered; the response is visible exactly 1 cycle after the grant cycle.
- Non-target hosts: rvalid=0, err=0, rdata=0.
- Back-to-back: a new grant may occur in the same cycle as the previous response; throughput is 1 access per cycle.
- Protocol errors:
  - mem_rvalid_i high with pend_valid=0 is ignored.
  - pend_valid=1, non-error, with mem_rvalid_i low: rvalid is still asserted and rdata is whatever mem_rdata_i presents. RAM latency is fixed, so this case is an assertion target only.
- Reset mid-operation: a pending response is dropped and no rvalid follows after reset deasserts.
- Assertions (bound in simulation):
  - host_gnt_o is onehot0.
  - mem_req_o implies |host_gnt_o.
  - Every grant is followed by exactly one rvalid to the same host.

Test Plan:
- Single host 0 writes addr 0x10, be 4'b1111, data 0xDEADBEEF; then reads 0x10 -> gnt same cycle; next cycle host_rvalid_o=2'b01, host_rdata_o[31:0]=0xDEADBEEF, err=0.
- NumHosts=2, both requesting reads continuously for 4 cycles from reset -> grants in order h0,h1,h0,h1; each rvalid arrives 1 cycle after its grant, to the matching host.
- NumHosts=3, hosts 1 and 2 requesting, pointer=2 -> h2 granted, pointer wraps to 0, then h1 granted.
- Host 1 reads addr 0x200 with Depth=128 (word 128) -> grant, mem_req_o=0, next cycle host_rvalid_o[1]=1, host_err_o[1]=1, rdata=0; then addr 0x1FC -> normal response, err=0.
- Byte-enable write be=4'b0010, data 0x0000AB00 to a word holding 0x11223344 -> subsequent read returns 0x1122AB44.
- Grant in cycle N, rst_i pulsed asynchronously mid-cycle N+1 -> rvalid forced 0, pointer=0, no response after release; the first request after release is granted to host 0.
